// File: rtl/cam_ctrl_pkg.sv
// Shared encodings for the CAM command front-end: opcodes, response status and FSM states.
package cam_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_FLUSH  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_MISS = 2'd1,
        ST_DUP  = 2'd2,
        ST_FULL = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StLk1,
        StLk2,
        StWrIssue,
        StWrWait,
        StFlScan,
        StResp
    } state_e;

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder; LSB_PRIORITY "HIGH" makes the lowest set index win, anything else the highest.
module priority_encoder #(
    parameter int unsigned WIDTH        = 4,
    parameter string       LSB_PRIORITY = "LOW"
) (
    input  logic [WIDTH-1:0]                                input_unencoded,
    output logic                                            output_valid,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]    output_encoded
);

    localparam int unsigned EncW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    always_comb begin
        output_valid   = |input_unencoded;
        output_encoded = '0;
        if (LSB_PRIORITY == "HIGH") begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (input_unencoded[i]) output_encoded = EncW'(i);
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (input_unencoded[i]) output_encoded = EncW'(i);
            end
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// Command front-end for the shift-register CAM: serialises LOOKUP/INSERT/DELETE/FLUSH,
// tracks occupancy in a bitmap and returns one response per command.
module cam_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_key,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [ADDR_WIDTH:0]   occ_count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] OccOne  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] OccFull = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [DATA_WIDTH-1:0]   key_q, key_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [ADDR_WIDTH:0]     occ_q, occ_d;
    logic                    rsp_valid_q, rsp_valid_d;
    status_e                 rsp_status_q, rsp_status_d;
    logic [ADDR_WIDTH-1:0]   rsp_addr_q, rsp_addr_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    wr_del_q, wr_del_d;
    logic                    wr_en_q, wr_en_d;

    logic                    free_valid, scan_valid;
    logic [ADDR_WIDTH-1:0]   free_idx, scan_idx;

    priority_encoder #(
        .WIDTH        (DEPTH),
        .LSB_PRIORITY ("HIGH")
    ) u_free_enc (
        .input_unencoded (~valid_q),
        .output_valid    (free_valid),
        .output_encoded  (free_idx)
    );

    priority_encoder #(
        .WIDTH        (DEPTH),
        .LSB_PRIORITY ("HIGH")
    ) u_scan_enc (
        .input_unencoded (valid_q),
        .output_valid    (scan_valid),
        .output_encoded  (scan_idx)
    );

    assign cmd_ready        = (state_q == StIdle) && !rsp_valid_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_status       = rsp_status_q;
    assign rsp_addr         = rsp_addr_q;
    assign cam_write_addr   = wr_addr_q;
    assign cam_write_data   = wr_data_q;
    assign cam_write_delete = wr_del_q;
    assign cam_write_enable = wr_en_q;
    assign cam_compare_data = key_q;
    assign occ_count        = occ_q;
    assign full             = (occ_q == OccFull);
    assign empty            = (occ_q == '0);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        key_d        = key_q;
        valid_d      = valid_q;
        occ_d        = occ_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_status_d = rsp_status_q;
        rsp_addr_d   = rsp_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_del_d     = wr_del_q;
        wr_en_d      = 1'b0;

        unique case (state_q)
            StInit: begin
                if (!cam_write_busy) state_d = StIdle;
            end
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = op_e'(cmd_op);
                    key_d   = cmd_key;
                    state_d = (op_e'(cmd_op) == OP_FLUSH) ? StFlScan : StLk1;
                end
            end
            StLk1: state_d = StLk2;
            StLk2: begin
                rsp_valid_d  = 1'b1;
                rsp_status_d = ST_OK;
                rsp_addr_d   = '0;
                state_d      = StResp;
                unique case (op_q)
                    OP_INSERT: begin
                        if (cam_match) begin
                            rsp_status_d = ST_DUP;
                            rsp_addr_d   = cam_match_addr;
                        end else if (full || !free_valid) begin
                            rsp_status_d = ST_FULL;
                        end else begin
                            rsp_valid_d = 1'b0;
                            wr_addr_d   = free_idx;
                            wr_data_d   = key_q;
                            wr_del_d    = 1'b0;
                            wr_en_d     = 1'b1;
                            state_d     = StWrIssue;
                        end
                    end
                    OP_DELETE: begin
                        if (!cam_match) begin
                            rsp_status_d = ST_MISS;
                        end else begin
                            rsp_valid_d = 1'b0;
                            wr_addr_d   = cam_match_addr;
                            wr_data_d   = key_q;
                            wr_del_d    = 1'b1;
                            wr_en_d     = 1'b1;
                            state_d     = StWrIssue;
                        end
                    end
                    default: begin
                        if (cam_match) rsp_addr_d = cam_match_addr;
                        else           rsp_status_d = ST_MISS;
                    end
                endcase
            end
            StWrIssue: state_d = StWrWait;
            StWrWait: begin
                // Address/data stay on the CAM port until busy drops; the CAM samples them live.
                if (!cam_write_busy) begin
                    valid_d[wr_addr_q] = !wr_del_q;
                    occ_d = wr_del_q ? (occ_q - OccOne) : (occ_q + OccOne);
                    if (op_q == OP_FLUSH) begin
                        state_d = StFlScan;
                    end else begin
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_OK;
                        rsp_addr_d   = wr_addr_q;
                        state_d      = StResp;
                    end
                end
            end
            StFlScan: begin
                if (scan_valid) begin
                    wr_addr_d = scan_idx;
                    wr_data_d = key_q;
                    wr_del_d  = 1'b1;
                    wr_en_d   = 1'b1;
                    state_d   = StWrIssue;
                end else begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_addr_d   = '0;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            op_q         <= OP_LOOKUP;
            key_q        <= '0;
            valid_q      <= '0;
            occ_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_addr_q   <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_del_q     <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            key_q        <= key_d;
            valid_q      <= valid_d;
            occ_q        <= occ_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_addr_q   <= rsp_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_del_q     <= wr_del_d;
            wr_en_q      <= wr_en_d;
        end
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl against a small behavioural shift-register CAM model.
module tb_cam_ctrl;
    import cam_ctrl_pkg::*;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]    cmd_op, rsp_status;
    logic [DW-1:0] cmd_key, cam_write_data, cam_compare_data;
    logic [AW-1:0] rsp_addr, cam_write_addr, cam_match_addr;
    logic          cam_write_delete, cam_write_enable, cam_write_busy, cam_match;
    logic [AW:0]   occ_count;
    logic          full, empty;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_addr(rsp_addr),
        .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
        .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
        .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
        .cam_match(cam_match), .cam_match_addr(cam_match_addr),
        .occ_count(occ_count), .full(full), .empty(empty)
    );

    // CAM model: 16-cycle self-clear after reset, 4-cycle busy per write, registered match vector.
    logic [DW-1:0] cam_ent [32];
    logic [31:0]   cam_v, cam_mv;
    int            cam_cnt;
    logic          cam_wr_pend;

    assign cam_write_busy = (cam_cnt != 0);
    assign cam_match      = |cam_mv;

    always_comb begin
        cam_match_addr = '0;
        for (int i = 31; i >= 0; i--) if (cam_mv[i]) cam_match_addr = 5'(i);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_v       <= '0;
            cam_mv      <= '0;
            cam_cnt     <= 16;
            cam_wr_pend <= 1'b0;
            for (int i = 0; i < 32; i++) cam_ent[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) cam_mv[i] <= cam_v[i] && (cam_ent[i] == cam_compare_data);
            if (cam_cnt != 0) begin
                if (cam_cnt == 1 && cam_wr_pend) begin
                    cam_wr_pend <= 1'b0;
                    if (cam_write_delete) cam_v[cam_write_addr] <= 1'b0;
                    else begin
                        cam_ent[cam_write_addr] <= cam_write_data;
                        cam_v[cam_write_addr]   <= 1'b1;
                    end
                end
                cam_cnt <= cam_cnt - 1;
            end else if (cam_write_enable) begin
                cam_cnt     <= 4;
                cam_wr_pend <= 1'b1;
            end
        end
    end

    // A CAM hit on an address the controller believes is free means the bitmap has diverged.
    always @(negedge clk) begin
        if (rst_n && dut.state_q == StLk2 && cam_match && !dut.valid_q[cam_match_addr]) begin
            miscompares++;
            $display("FAIL match_on_free_slot: addr %0d hit but bitmap bit clear", cam_match_addr);
        end
    end

    // Issue one command and accept its response; called and returns at a negedge.
    task automatic do_cmd(input op_e op, input logic [DW-1:0] key,
                          output logic [1:0] st, output logic [AW-1:0] ad, output int lat);
        int n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL cmd_ready_timeout: cmd_ready %b, want 1 within 200 cycles", cmd_ready);
            st = 2'bxx; ad = 'x; lat = -1;
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_key = key;
        @(posedge clk); #1 cmd_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 1000);
        if (!rsp_valid) begin
            miscompares++;
            $display("FAIL rsp_timeout: rsp_valid %b, want 1 within 1000 cycles", rsp_valid);
        end
        st = rsp_status; ad = rsp_addr;
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: cmd_ready %b, want 1 within 100 cycles", name, cmd_ready);
        end
    endtask

    task automatic test_reset();
        logic [1:0] st; logic [AW-1:0] ad; int lat;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; rsp_ready = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready, rsp_valid, cam_write_enable, cam_write_delete, full, empty,
             rsp_status, rsp_addr, occ_count, cam_write_addr} !== {6'b000001, 2'b0, 5'b0, 6'b0, 5'b0}) begin
            miscompares++;
            $display("FAIL reset_values: rdy/rv/we/wd/full/empty %b%b%b%b%b%b st %0d addr %0d occ %0d, want 000001 0 0 0",
                     cmd_ready, rsp_valid, cam_write_enable, cam_write_delete, full, empty,
                     rsp_status, rsp_addr, occ_count);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL init_not_ready: cmd_ready %b during CAM clear, want 0", cmd_ready);
        end
        wait_ready("init_done");
        do_cmd(OP_LOOKUP, 64'h1234, st, ad, lat);
        vectors++;
        if ({st, ad, occ_count, empty} !== {ST_MISS, 5'd0, 6'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL lookup_after_reset: st %0d addr %0d occ %0d empty %b, want 1 0 0 1",
                     st, ad, occ_count, empty);
        end
    endtask

    task automatic test_insert_lookup();
        logic [1:0] st; logic [AW-1:0] ad; int lat;
        do_cmd(OP_INSERT, 64'hDEADBEEF, st, ad, lat);
        vectors++;
        if ({st, ad} !== {ST_OK, 5'd0}) begin
            miscompares++; $display("FAIL insert_deadbeef: st %0d addr %0d, want 0 0", st, ad);
        end
        do_cmd(OP_INSERT, 64'hCAFE, st, ad, lat);
        vectors++;
        if ({st, ad} !== {ST_OK, 5'd1}) begin
            miscompares++; $display("FAIL insert_cafe: st %0d addr %0d, want 0 1", st, ad);
        end
        do_cmd(OP_LOOKUP, 64'hCAFE, st, ad, lat);
        vectors++;
        if ({st, ad} !== {ST_OK, 5'd1} || lat != 3) begin
            miscompares++;
            $display("FAIL lookup_cafe: st %0d addr %0d lat %0d, want 0 1 3", st, ad, lat);
        end
        vectors++;
        if (occ_count !== 6'd2 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL occ_two: occ %0d empty %b, want 2 0", occ_count, empty);
        end
    endtask

    task automatic test_dup_delete();
        logic [1:0] st; logic [AW-1:0] ad; int lat;
        do_cmd(OP_INSERT, 64'hDEADBEEF, st, ad, lat);
        vectors++;
        if ({st, ad, occ_count} !== {ST_DUP, 5'd0, 6'd2}) begin
            miscompares++;
            $display("FAIL insert_dup: st %0d addr %0d occ %0d, want 2 0 2", st, ad, occ_count);
        end
        do_cmd(OP_DELETE, 64'hDEADBEEF, st, ad, lat);
        vectors++;
        if ({st, ad, occ_count} !== {ST_OK, 5'd0, 6'd1}) begin
            miscompares++;
            $display("FAIL delete_deadbeef: st %0d addr %0d occ %0d, want 0 0 1", st, ad, occ_count);
        end
        do_cmd(OP_INSERT, 64'h77, st, ad, lat);
        vectors++;
        if ({st, ad, occ_count} !== {ST_OK, 5'd0, 6'd2}) begin
            miscompares++;
            $display("FAIL reuse_lowest_free: st %0d addr %0d occ %0d, want 0 0 2", st, ad, occ_count);
        end
    endtask

    task automatic test_fill();
        logic [1:0] st; logic [AW-1:0] ad; int lat;
        for (int i = 0; i < 30; i++) begin
            do_cmd(OP_INSERT, 64'h1000 + 64'(i), st, ad, lat);
            vectors++;
            if ({st, ad} !== {ST_OK, 5'(i + 2)}) begin
                miscompares++;
                $display("FAIL fill_%0d: st %0d addr %0d, want 0 %0d", i, st, ad, i + 2);
            end
        end
        vectors++;
        if ({full, empty, occ_count} !== {1'b1, 1'b0, 6'd32}) begin
            miscompares++;
            $display("FAIL full_flag: full %b empty %b occ %0d, want 1 0 32", full, empty, occ_count);
        end
        do_cmd(OP_INSERT, 64'h9999, st, ad, lat);
        vectors++;
        if ({st, occ_count} !== {ST_FULL, 6'd32}) begin
            miscompares++;
            $display("FAIL insert_when_full: st %0d occ %0d, want 3 32", st, occ_count);
        end
        do_cmd(OP_DELETE, 64'h5555, st, ad, lat);
        vectors++;
        if ({st, ad} !== {ST_MISS, 5'd0}) begin
            miscompares++; $display("FAIL delete_absent: st %0d addr %0d, want 1 0", st, ad);
        end
    endtask

    task automatic test_flush_hold();
        logic [1:0] st; logic [AW-1:0] ad; int lat; int n;
        logic [1:0] st0; logic [AW-1:0] ad0;
        wait_ready("flush_ready");
        cmd_valid = 1'b1; cmd_op = OP_FLUSH; cmd_key = '0;
        @(posedge clk); #1 cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 1000);
        st0 = rsp_status; ad0 = rsp_addr;
        vectors++;
        if ({rsp_valid, st0, ad0, occ_count, empty} !== {1'b1, ST_OK, 5'd0, 6'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_full: rv %b st %0d addr %0d occ %0d empty %b, want 1 0 0 0 1",
                     rsp_valid, st0, ad0, occ_count, empty);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, cmd_ready, rsp_status, rsp_addr} !== {2'b10, ST_OK, 5'd0}) begin
                miscompares++;
                $display("FAIL rsp_hold_%0d: rv %b rdy %b st %0d addr %0d, want 1 0 0 0",
                         i, rsp_valid, cmd_ready, rsp_status, rsp_addr);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL rsp_drop: rsp_valid %b, want 0", rsp_valid);
        end
        do_cmd(OP_LOOKUP, 64'hCAFE, st, ad, lat);
        vectors++;
        if ({st, ad} !== {ST_MISS, 5'd0}) begin
            miscompares++; $display("FAIL lookup_after_flush: st %0d addr %0d, want 1 0", st, ad);
        end
        do_cmd(OP_LOOKUP, 64'h1005, st, ad, lat);
        vectors++;
        if (st !== ST_MISS) begin
            miscompares++; $display("FAIL lookup2_after_flush: st %0d, want 1", st);
        end
        do_cmd(OP_FLUSH, '0, st, ad, lat);
        vectors++;
        if ({st, ad} !== {ST_OK, 5'd0} || lat != 2) begin
            miscompares++;
            $display("FAIL flush_empty: st %0d addr %0d lat %0d, want 0 0 2", st, ad, lat);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] st; logic [AW-1:0] ad; int lat; int n;
        do_cmd(OP_INSERT, 64'h42, st, ad, lat);
        vectors++;
        if ({st, ad, occ_count} !== {ST_OK, 5'd0, 6'd1}) begin
            miscompares++;
            $display("FAIL insert_42: st %0d addr %0d occ %0d, want 0 0 1", st, ad, occ_count);
        end
        wait_ready("mid_write_ready");
        cmd_valid = 1'b1; cmd_op = OP_INSERT; cmd_key = 64'hABCD;
        @(posedge clk); #1 cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!cam_write_busy && n < 20);
        vectors++;
        if (cam_write_busy !== 1'b1 || cam_write_addr !== 5'd1) begin
            miscompares++;
            $display("FAIL write_in_flight: busy %b addr %0d, want 1 1", cam_write_busy, cam_write_addr);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready, rsp_valid, cam_write_enable, cam_write_delete, full, empty,
             occ_count, cam_write_addr, cam_write_data} !== {6'b000001, 6'd0, 5'd0, 64'd0}) begin
            miscompares++;
            $display("FAIL reset_mid_write: rdy/rv/we/wd/full/empty %b%b%b%b%b%b occ %0d waddr %0d wdata %h, want 000001 0 0 0",
                     cmd_ready, rsp_valid, cam_write_enable, cam_write_delete, full, empty,
                     occ_count, cam_write_addr, cam_write_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reinit_done");
        do_cmd(OP_LOOKUP, 64'hABCD, st, ad, lat);
        vectors++;
        if ({st, occ_count} !== {ST_MISS, 6'd0}) begin
            miscompares++;
            $display("FAIL lookup_after_reinit: st %0d occ %0d, want 1 0", st, occ_count);
        end
    endtask

    initial begin
        test_reset();
        test_insert_lookup();
        test_dup_delete();
        test_fill();
        test_flush_hold();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
